// File: rtl/svm_order_gen.sv
// Turns SVM classifier results into single order requests with thresholds, position limit and
// post-order cooldown. Define SIGNAL_CONFIRM_EN to require CONFIRM_COUNT consecutive agreeing samples.
module svm_order_gen #(
    parameter int          DATA_WIDTH      = 16,
    parameter int          FRAC_BITS       = 8,
    parameter int          POS_WIDTH       = 16,
    parameter int unsigned ORDER_QTY       = 1,
    parameter int unsigned MAX_POS         = 100,
    parameter int unsigned COOLDOWN_CYCLES = 16,
    parameter int unsigned CONFIRM_COUNT   = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         trade_en,
    input  logic                         svm_valid,
    input  logic signed [DATA_WIDTH-1:0] svm_decision,
    input  logic                         svm_prediction,
    input  logic signed [DATA_WIDTH-1:0] buy_thresh,
    input  logic signed [DATA_WIDTH-1:0] sell_thresh,
    output logic                         order_valid,
    input  logic                         order_ready,
    output logic                         order_side,
    output logic        [POS_WIDTH-1:0]  order_qty,
    output logic signed [POS_WIDTH-1:0]  position,
    output logic                         limit_hit,
    output logic        [15:0]           drop_count
);

    localparam int PW1   = POS_WIDTH + 1;
    localparam int CNT_W = $clog2(COOLDOWN_CYCLES + 2);

    localparam logic signed [POS_WIDTH:0]   QTY_EXT     = PW1'(ORDER_QTY);
    localparam logic signed [POS_WIDTH:0]   MAX_EXT     = PW1'(MAX_POS);
    localparam logic signed [POS_WIDTH:0]   NEG_MAX_EXT = -MAX_EXT;
    localparam logic signed [POS_WIDTH-1:0] QTY_POS     = POS_WIDTH'(ORDER_QTY);

    typedef enum logic [1:0] {StIdle, StIssue, StCooldown} state_e;

    state_e             state;
    logic [CNT_W-1:0]   cd_cnt;

    logic               buy_q;
    logic               sell_q;
    logic               allowed;
    logic               eval;
    logic               fire;
    logic               blocked;
    logic signed [POS_WIDTH:0] pos_ext;
    logic signed [POS_WIDTH:0] pos_plus;
    logic signed [POS_WIDTH:0] pos_minus;

    logic unused_params;
    assign unused_params = ^{FRAC_BITS, CONFIRM_COUNT};

    always_comb begin
        buy_q     = svm_prediction && (svm_decision >= buy_thresh);
        sell_q    = !svm_prediction && (svm_decision <= sell_thresh);
        // Limit math is one bit wider than position so it cannot wrap.
        pos_ext   = PW1'(position);
        pos_plus  = pos_ext + QTY_EXT;
        pos_minus = pos_ext - QTY_EXT;
        allowed   = buy_q ? (pos_plus <= MAX_EXT) : (pos_minus >= NEG_MAX_EXT);
        eval      = (state == StIdle) && svm_valid && trade_en && (buy_q || sell_q);
        blocked   = eval && !allowed;
    end

`ifdef SIGNAL_CONFIRM_EN
    localparam int SW = $clog2(CONFIRM_COUNT + 1);

    logic [SW-1:0] streak;
    logic          streak_side;
    logic [SW-1:0] streak_next;

    always_comb begin
        streak_next = ((streak != '0) && (streak_side == sell_q)) ? streak + SW'(1) : SW'(1);
        fire        = eval && allowed && (streak_next >= SW'(CONFIRM_COUNT));
    end
`else
    assign fire = eval && allowed;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            order_valid <= 1'b0;
            order_side  <= 1'b0;
            order_qty   <= '0;
            position    <= '0;
            limit_hit   <= 1'b0;
            drop_count  <= '0;
            cd_cnt      <= '0;
`ifdef SIGNAL_CONFIRM_EN
            streak      <= '0;
            streak_side <= 1'b0;
`endif
        end else begin
            limit_hit <= 1'b0;
            // Pulses arriving while busy are counted, never evaluated.
            if ((state != StIdle) && svm_valid && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
            case (state)
                StIdle: begin
                    if (fire) begin
                        order_valid <= 1'b1;
                        order_side  <= sell_q;
                        order_qty   <= QTY_POS;
                        state       <= StIssue;
`ifdef SIGNAL_CONFIRM_EN
                        streak      <= '0;
`endif
                    end else if (blocked) begin
                        limit_hit <= 1'b1;
`ifdef SIGNAL_CONFIRM_EN
                        streak    <= '0;
`endif
                    end
`ifdef SIGNAL_CONFIRM_EN
                    else if (eval) begin
                        streak      <= streak_next;
                        streak_side <= sell_q;
                    end else if (!trade_en || svm_valid) begin
                        streak <= '0;
                    end
`endif
                end
                StIssue: begin
                    if (order_ready) begin
                        order_valid <= 1'b0;
                        position    <= order_side ? position - QTY_POS : position + QTY_POS;
                        cd_cnt      <= CNT_W'(COOLDOWN_CYCLES);
                        state       <= (COOLDOWN_CYCLES == 0) ? StIdle : StCooldown;
                    end
                end
                StCooldown: begin
                    cd_cnt <= cd_cnt - CNT_W'(1);
                    if (cd_cnt == CNT_W'(1)) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
